// File: rtl/pl_mips_pkg.sv
// Shared encodings for the EX-stage ALU control and the mul/div engine.
package pl_mips_pkg;

    // Main-decoder ALU op
    localparam logic [1:0] ALU_OP_LW_SW  = 2'b00;
    localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;

    // ALU control codes
    localparam logic [3:0] ALU_CTRL_AND = 4'b0000;
    localparam logic [3:0] ALU_CTRL_OR  = 4'b0001;
    localparam logic [3:0] ALU_CTRL_ADD = 4'b0010;
    localparam logic [3:0] ALU_CTRL_XOR = 4'b0011;
    localparam logic [3:0] ALU_CTRL_SUB = 4'b0110;
    localparam logic [3:0] ALU_CTRL_SLT = 4'b0111;
    localparam logic [3:0] ALU_CTRL_NOR = 4'b1100;

    // R-type funct field
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
    localparam logic [5:0] FUNCT_ADD   = 6'h20;
    localparam logic [5:0] FUNCT_SUB   = 6'h22;
    localparam logic [5:0] FUNCT_AND   = 6'h24;
    localparam logic [5:0] FUNCT_OR    = 6'h25;
    localparam logic [5:0] FUNCT_XOR   = 6'h26;
    localparam logic [5:0] FUNCT_NOR   = 6'h27;
    localparam logic [5:0] FUNCT_SLT   = 6'h2A;

    typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;
    typedef enum logic [1:0] {MUL_S, MUL_U, DIV_S, DIV_U} md_op_t;

    function automatic logic op_is_signed(input md_op_t op);
        return (op == MUL_S) || (op == DIV_S);
    endfunction

    function automatic logic op_is_div(input md_op_t op);
        return (op == DIV_S) || (op == DIV_U);
    endfunction

endpackage

// File: rtl/pl_muldiv_iter.sv
// Iterative multiply / restoring divide on operand magnitudes, with the
// sign fix-up folded into the final iteration so the result is ready on done.
module pl_muldiv_iter
    import pl_mips_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic            i_abort,
    input  md_op_t          i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_done,
    output logic [XLEN-1:0] o_hi,
    output logic [XLEN-1:0] o_lo
);

    localparam int N  = XLEN / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);

    logic [XLEN-1:0]   r_acc_hi;
    logic [XLEN-1:0]   r_acc_lo;
    logic [XLEN-1:0]   r_opb;
    logic [CW-1:0]     r_count;
    logic              r_is_div;
    logic              r_neg_lo;
    logic              r_neg_hi;

    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_hi_nx;
    logic [XLEN-1:0]   w_lo_nx;
    logic [XLEN:0]     w_shift;
    logic [XLEN:0]     w_diff;
    logic [XLEN:0]     w_sum;
    logic [2*XLEN-1:0] w_prod_fix;

    assign w_a_neg = op_is_signed(i_op) & i_a[XLEN-1];
    assign w_b_neg = op_is_signed(i_op) & i_b[XLEN-1];
    assign o_done  = (r_count == CW'(1));

    // BITS_PER_CYCLE steps of shift-add (multiply) or restoring subtract (divide)
    always_comb begin
        w_hi_nx = r_acc_hi;
        w_lo_nx = r_acc_lo;
        w_shift = '0;
        w_diff  = '0;
        w_sum   = '0;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            if (r_is_div) begin
                w_shift = {w_hi_nx, w_lo_nx[XLEN-1]};
                w_diff  = w_shift - {1'b0, r_opb};
                if (!w_diff[XLEN]) begin
                    w_hi_nx = w_diff[XLEN-1:0];
                    w_lo_nx = {w_lo_nx[XLEN-2:0], 1'b1};
                end else begin
                    w_hi_nx = w_shift[XLEN-1:0];
                    w_lo_nx = {w_lo_nx[XLEN-2:0], 1'b0};
                end
            end else begin
                w_sum   = {1'b0, w_hi_nx} + (w_lo_nx[0] ? {1'b0, r_opb} : '0);
                w_lo_nx = {w_sum[0], w_lo_nx[XLEN-1:1]};
                w_hi_nx = w_sum[XLEN:1];
            end
        end
    end

    // Sign fix-up: product negated as a whole; quotient and remainder separately
    always_comb begin
        w_prod_fix = '0;
        if (r_is_div) begin
            o_lo = r_neg_lo ? -w_lo_nx : w_lo_nx;
            o_hi = r_neg_hi ? -w_hi_nx : w_hi_nx;
        end else begin
            w_prod_fix = r_neg_lo ? -{w_hi_nx, w_lo_nx} : {w_hi_nx, w_lo_nx};
            o_hi       = w_prod_fix[2*XLEN-1:XLEN];
            o_lo       = w_prod_fix[XLEN-1:0];
        end
    end

    // Operand load on start, one iteration per cycle while the counter runs
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_opb    <= '0;
            r_count  <= '0;
            r_is_div <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
        end else if (i_abort) begin
            r_count <= '0;
        end else if (i_start) begin
            r_acc_hi <= '0;
            r_acc_lo <= w_a_neg ? -i_a : i_a;
            r_opb    <= w_b_neg ? -i_b : i_b;
            r_is_div <= op_is_div(i_op);
            r_neg_lo <= w_a_neg ^ w_b_neg;
            r_neg_hi <= w_a_neg;
            r_count  <= CW'(N);
        end else if (r_count != '0) begin
            r_acc_hi <= w_hi_nx;
            r_acc_lo <= w_lo_nx;
            r_count  <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/pl_alu_control_md.sv
// EX-stage ALU control with HI/LO registers and a multi-cycle mul/div engine.
// state   | meaning
// MD_IDLE | no mul/div in flight; a mul/div in EX starts here
// MD_BUSY | engine iterating, EX held by stall
// MD_DONE | HI/LO valid, instruction leaves EX, no re-accept
module pl_alu_control_md
    import pl_mips_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_ex,
    input  logic            flush,
    input  logic [1:0]      alu_op,
    input  logic [5:0]      funct,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic [3:0]      alu_control,
    output logic [1:0]      hilo_rd_sel,
    output logic            undefined_instr,
    output logic            stall,
    output logic            busy,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    md_state_t       r_state;
    md_state_t       w_state_nx;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;

    logic            w_unsup;
    logic            w_is_muldiv;
    logic            w_is_mthi;
    logic            w_is_mtlo;
    md_op_t          w_op;
    logic            w_start;
    logic            w_div_zero;
    logic            w_mt_wr;
    logic            w_eng_done;
    logic [XLEN-1:0] w_res_hi;
    logic [XLEN-1:0] w_res_lo;

    assign hi              = r_hi;
    assign lo              = r_lo;
    assign undefined_instr = valid_ex & w_unsup;
    assign w_div_zero      = op_is_div(w_op) & (src_b == '0);
    assign w_mt_wr         = valid_ex & ~flush & ~stall & (r_state == MD_IDLE);

    // Instruction decode: ALU code, HI/LO read select, mul/div and move classification
    always_comb begin
        alu_control = ALU_CTRL_ADD;
        hilo_rd_sel = 2'b00;
        w_unsup     = 1'b0;
        w_is_muldiv = 1'b0;
        w_is_mthi   = 1'b0;
        w_is_mtlo   = 1'b0;
        w_op        = MUL_S;
        case (alu_op)
            ALU_OP_LW_SW:  alu_control = ALU_CTRL_ADD;
            ALU_OP_BRANCH: alu_control = ALU_CTRL_SUB;
            ALU_OP_RTYPE: begin
                case (funct)
                    FUNCT_ADD:   alu_control = ALU_CTRL_ADD;
                    FUNCT_SUB:   alu_control = ALU_CTRL_SUB;
                    FUNCT_AND:   alu_control = ALU_CTRL_AND;
                    FUNCT_OR:    alu_control = ALU_CTRL_OR;
                    FUNCT_SLT:   alu_control = ALU_CTRL_SLT;
                    FUNCT_NOR:   alu_control = ALU_CTRL_NOR;
                    FUNCT_XOR:   alu_control = ALU_CTRL_XOR;
                    FUNCT_MULT:  begin w_is_muldiv = 1'b1; w_op = MUL_S; end
                    FUNCT_MULTU: begin w_is_muldiv = 1'b1; w_op = MUL_U; end
                    FUNCT_DIV:   begin w_is_muldiv = 1'b1; w_op = DIV_S; end
                    FUNCT_DIVU:  begin w_is_muldiv = 1'b1; w_op = DIV_U; end
                    FUNCT_MFHI:  hilo_rd_sel = 2'b01;
                    FUNCT_MFLO:  hilo_rd_sel = 2'b10;
                    FUNCT_MTHI:  w_is_mthi = 1'b1;
                    FUNCT_MTLO:  w_is_mtlo = 1'b1;
                    default:     w_unsup = 1'b1;
                endcase
            end
            default: w_unsup = 1'b1;
        endcase
    end

    // Next-state, start and stall; divide by zero bypasses the engine entirely
    always_comb begin
        w_state_nx = r_state;
        w_start    = valid_ex & ~flush & w_is_muldiv & (r_state == MD_IDLE);
        stall      = w_start | (r_state == MD_BUSY);
        busy       = (r_state != MD_IDLE);
        case (r_state)
            MD_IDLE: if (w_start) w_state_nx = w_div_zero ? MD_DONE : MD_BUSY;
            MD_BUSY: begin
                if (flush)           w_state_nx = MD_IDLE;
                else if (w_eng_done) w_state_nx = MD_DONE;
            end
            MD_DONE: w_state_nx = MD_IDLE;
            default: w_state_nx = MD_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= MD_IDLE;
        else       r_state <= w_state_nx;
    end

    // HI/LO update: divide-by-zero result, engine result, or MTHI/MTLO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_start && w_div_zero) begin
            r_hi <= src_a;
            r_lo <= '1;
        end else if ((r_state == MD_BUSY) && !flush && w_eng_done) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
        end else if (w_mt_wr) begin
            if (w_is_mthi) r_hi <= src_a;
            if (w_is_mtlo) r_lo <= src_a;
        end
    end

    pl_muldiv_iter #(
        .XLEN           (XLEN),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_muldiv (
        .clk     (clk),
        .i_rst   (reset),
        .i_start (w_start & ~w_div_zero),
        .i_abort ((r_state == MD_BUSY) & flush),
        .i_op    (w_op),
        .i_a     (src_a),
        .i_b     (src_b),
        .o_done  (w_eng_done),
        .o_hi    (w_res_hi),
        .o_lo    (w_res_lo)
    );

endmodule

// File: tb/tb_pl_alu_control_md.sv
// Self-checking bench for pl_alu_control_md: directed scenarios plus random
// decode and random mul/div checked against a 64-bit arithmetic reference.
module tb_pl_alu_control_md;

    localparam logic [3:0] C_AND = 4'b0000, C_OR = 4'b0001, C_ADD = 4'b0010,
                           C_XOR = 4'b0011, C_SUB = 4'b0110, C_SLT = 4'b0111,
                           C_NOR = 4'b1100;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_ex, flush;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [31:0] src_a, src_b;
    logic [3:0]  alu_control;
    logic [1:0]  hilo_rd_sel;
    logic        undefined_instr, stall, busy;
    logic [31:0] hi, lo;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    pl_alu_control_md dut (
        .clk(clk), .reset(reset), .valid_ex(valid_ex), .flush(flush),
        .alu_op(alu_op), .funct(funct), .src_a(src_a), .src_b(src_b),
        .alu_control(alu_control), .hilo_rd_sel(hilo_rd_sel),
        .undefined_instr(undefined_instr), .stall(stall), .busy(busy),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Decode reference: {alu_control, undefined_instr, hilo_rd_sel}
    function automatic logic [6:0] dec_ref(input logic [1:0] op, input logic [5:0] f, input logic v);
        logic [3:0] c;
        logic       u;
        logic [1:0] s;
        c = C_ADD; u = 1'b0; s = 2'b00;
        if (op == 2'b01) c = C_SUB;
        else if (op == 2'b11) u = 1'b1;
        else if (op == 2'b10) begin
            case (f)
                6'h20: c = C_ADD;
                6'h22: c = C_SUB;
                6'h24: c = C_AND;
                6'h25: c = C_OR;
                6'h26: c = C_XOR;
                6'h27: c = C_NOR;
                6'h2A: c = C_SLT;
                6'h10: s = 2'b01;
                6'h12: s = 2'b10;
                6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B: c = C_ADD;
                default: u = 1'b1;
            endcase
        end
        return {c, u & v, s};
    endfunction

    // Arithmetic reference for MULT/MULTU/DIV/DIVU
    task automatic md_ref(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] rh, output logic [31:0] rl);
        longint      sa, sb, sp, sq, sr;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        rh = '0; rl = '0;
        case (f)
            6'h18: begin sp = sa * sb; rh = sp[63:32]; rl = sp[31:0]; end
            6'h19: begin up = {32'b0, a} * {32'b0, b}; rh = up[63:32]; rl = up[31:0]; end
            6'h1A: begin
                if (b == 0) begin rh = a; rl = 32'hFFFF_FFFF; end
                else begin sq = sa / sb; sr = sa % sb; rh = sr[31:0]; rl = sq[31:0]; end
            end
            default: begin
                if (b == 0) begin rh = a; rl = 32'hFFFF_FFFF; end
                else begin rh = a % b; rl = a / b; end
            end
        endcase
    endtask

    // Issue one mul/div, count stall cycles, check HI/LO in the DONE cycle
    task automatic run_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        int exp_len;
        int cyc;
        @(posedge clk); #1;
        valid_ex = 1'b1; flush = 1'b0; alu_op = 2'b10; funct = f; src_a = a; src_b = b;
        md_ref(f, a, b, m_hi, m_lo);
        exp_len = ((f == 6'h1A || f == 6'h1B) && b == 0) ? 1 : 33;
        cyc = 0;
        @(negedge clk);
        while (stall && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        chk($sformatf("stall_len f=%0h", f), 64'(cyc), 64'(exp_len));
        chk($sformatf("busy_done f=%0h", f), {63'b0, busy}, 64'd1);
        chk($sformatf("hi f=%0h a=%0h b=%0h", f, a, b), {32'b0, hi}, {32'b0, m_hi});
        chk($sformatf("lo f=%0h a=%0h b=%0h", f, a, b), {32'b0, lo}, {32'b0, m_lo});
        @(posedge clk); #1;
        valid_ex = 1'b0;
    endtask

    task automatic dec_step(input logic v, input logic fl, input logic [1:0] op, input logic [5:0] f);
        logic [6:0] e;
        @(posedge clk); #1;
        valid_ex = v; flush = fl; alu_op = op; funct = f;
        e = dec_ref(op, f, v);
        @(negedge clk);
        chk($sformatf("alu_control op=%0d f=%0h", op, f), {60'b0, alu_control}, {60'b0, e[6:3]});
        chk($sformatf("undefined op=%0d f=%0h", op, f), {63'b0, undefined_instr}, {63'b0, e[2]});
        chk($sformatf("hilo_sel op=%0d f=%0h", op, f), {62'b0, hilo_rd_sel}, {62'b0, e[1:0]});
        chk($sformatf("stall_dec op=%0d f=%0h", op, f), {63'b0, stall}, 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; valid_ex = 1'b0; flush = 1'b0;
        alu_op = 2'b00; funct = 6'h00; src_a = '0; src_b = '0;
        repeat (2) @(negedge clk);
        chk("reset_stall", {63'b0, stall}, 64'd0);
        chk("reset_busy",  {63'b0, busy},  64'd0);
        chk("reset_hi",    {32'b0, hi},    64'd0);
        chk("reset_lo",    {32'b0, lo},    64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Basic R-type decode, unsupported funct, LW/SW and BRANCH, reserved op
        dec_step(1'b1, 1'b0, 2'b10, 6'h20);
        dec_step(1'b1, 1'b0, 2'b10, 6'h2A);
        dec_step(1'b1, 1'b0, 2'b10, 6'h3F);
        dec_step(1'b1, 1'b0, 2'b00, 6'h3F);
        dec_step(1'b1, 1'b0, 2'b01, 6'h00);
        dec_step(1'b1, 1'b0, 2'b11, 6'h20);
        dec_step(1'b0, 1'b0, 2'b11, 6'h20);

        // Random decode; flush keeps mul/div and moves from having side effects
        for (int i = 0; i < 24; i++)
            dec_step(1'($urandom_range(0, 1)), 1'b1, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)));
        @(posedge clk); #1;
        flush = 1'b0; valid_ex = 1'b0;
        @(negedge clk);
        chk("hi_after_flushed_decode", {32'b0, hi}, {32'b0, m_hi});
        chk("lo_after_flushed_decode", {32'b0, lo}, {32'b0, m_lo});

        // Directed mul/div
        run_md(6'h18, 32'hFFFF_FFFD, 32'd7);
        run_md(6'h1A, 32'hFFFF_FFF9, 32'd2);
        run_md(6'h1B, 32'd100, 32'd7);
        run_md(6'h1B, 32'h0000_1234, 32'd0);
        run_md(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF);

        // MTHI, then a MULTU flushed in its 10th BUSY cycle, then MFHI
        @(posedge clk); #1;
        valid_ex = 1'b1; alu_op = 2'b10; funct = 6'h11; src_a = 32'hAA;
        m_hi = 32'hAA;
        @(posedge clk); #1;
        funct = 6'h19; src_a = 32'd5; src_b = 32'd6;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        chk("stall_in_flush_cycle", {63'b0, stall}, 64'd1);
        @(posedge clk); #1;
        flush = 1'b0; valid_ex = 1'b0;
        @(negedge clk);
        chk("stall_after_flush", {63'b0, stall}, 64'd0);
        chk("busy_after_flush",  {63'b0, busy},  64'd0);
        chk("hi_after_flush",    {32'b0, hi},    64'h0000_00AA);
        chk("lo_after_flush",    {32'b0, lo},    {32'b0, m_lo});
        dec_step(1'b1, 1'b0, 2'b10, 6'h10);

        // MTLO path
        @(posedge clk); #1;
        valid_ex = 1'b1; funct = 6'h13; src_a = 32'h5A5A_0001;
        m_lo = 32'h5A5A_0001;
        @(posedge clk); #1;
        valid_ex = 1'b0;
        @(negedge clk);
        chk("lo_mtlo", {32'b0, lo}, {32'b0, m_lo});
        chk("hi_mtlo", {32'b0, hi}, {32'b0, m_hi});

        // Random mul/div
        for (int i = 0; i < 20; i++)
            run_md(6'h18 + 6'($urandom_range(0, 3)), pick(), pick());

        // Make HI/LO nonzero, then reset in the 5th BUSY cycle of a MULT
        run_md(6'h19, 32'h1234_5678, 32'h9ABC_DEF0);
        @(posedge clk); #1;
        valid_ex = 1'b1; alu_op = 2'b10; funct = 6'h18; src_a = 32'd11; src_b = 32'd13;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1; valid_ex = 1'b0;
        m_hi = '0; m_lo = '0;
        #1;
        chk("stall_on_reset", {63'b0, stall}, 64'd0);
        chk("busy_on_reset",  {63'b0, busy},  64'd0);
        chk("hi_on_reset",    {32'b0, hi},    64'd0);
        chk("lo_on_reset",    {32'b0, lo},    64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        run_md(6'h18, 32'hFFFF_FFFD, 32'd7);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
